// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM port arbiter
package rom_arb_pkg;
  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_state_t;
  localparam int WORD_BYTES = 4;
  localparam int DEPTH_DEF = 512;
  localparam int ROM_BYTES = DEPTH_DEF * WORD_BYTES;
endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: fetch and data read ports into the shared ROM
interface rom_port_arbiter_if #(parameter int ADDR_W = 12);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  modport master (
    output if_req, if_addr, d_req, d_addr,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err
  );
  modport slave (
    input  if_req, if_addr, d_req, d_addr,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one ROM between fetch and data reads with bounded fetch starvation
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 512,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  rom_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  rsp_state_t        rsp_q, rsp_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d, gnt_addr;
  logic [31:0]       if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d, d_bad;
  always_comb begin
    d_bad = bus.d_addr[1:0] != 2'b00 || 32'(bus.d_addr[ADDR_W-1:2]) >= 32'(DEPTH);
    bus.d_gnt = bus.d_req && !(bus.if_req && starve_q == MW);
    bus.if_gnt = bus.if_req && !bus.d_gnt;
    gnt_addr = bus.if_gnt ? bus.if_addr : bus.d_addr;
    // idle cycles replay the last address so the ROM output stays stable
    rom_addr = (bus.if_gnt || bus.d_gnt) ? (gnt_addr & ~ADDR_W'(3)) : last_addr_q;
    last_addr_d = rom_addr;
    starve_d = (!bus.if_req || bus.if_gnt) ? 4'd0 : (starve_q == MW ? MW : starve_q + 4'd1);
    rsp_d = bus.if_gnt ? RSP_IF : (bus.d_gnt ? RSP_D : RSP_NONE);
    if_rdata_d = bus.if_gnt ? rom_data : if_rdata_q;
    d_rdata_d = bus.d_gnt ? (d_bad ? 32'd0 : rom_data) : d_rdata_q;
    d_err_d = bus.d_gnt && d_bad;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q       <= RSP_NONE;
      starve_q    <= '0;
      last_addr_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      rsp_q       <= rsp_d;
      starve_q    <= starve_d;
      last_addr_q <= last_addr_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end
  always_comb begin
    bus.if_rvalid = rsp_q == RSP_IF;
    bus.d_rvalid  = rsp_q == RSP_D;
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;
    bus.d_err     = d_err_q;
  end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-ported instruction ROM between the core's instruction-fetch port and a data-side read port.
- The data-side port serves constant tables and self-check code from the ROM address space.
- Issues a registered read response with 1-cycle latency.
- Enforces a bounded-starvation priority between the two ports and flags illegal data accesses.
- Sits between the core's fetch/LSU read paths and the combinational ROM.

Parameters:
- ADDR_W, 12, byte-address width of ROM ports.
- DEPTH, 512, ROM depth in 32-bit words; word index = addr >> 2.
- MAX_WAIT, 4, consecutive denied cycles after which fetch wins over data (1..15).

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid (cycle after grant)
- if_rdata  out  32  fetch instruction word
- d_req  in  1  data read request; held with d_addr until d_gnt
- d_addr  in  ADDR_W  data byte address
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data response valid (cycle after grant)
- d_rdata  out  32  data word; 0 on error
- d_err  out  1  qualifies d_rvalid: misaligned or out-of-range access
- rom_addr  out  ADDR_W  byte address driven to ROM
- rom_data  in  32  ROM combinational read word

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values:
  - if_rvalid, d_rvalid, d_err = 0.
  - if_rdata, d_rdata = 0.
  - starve_cnt = 0, last_addr = 0, rsp_state = RSP_NONE.
- Arbitration (combinational, each cycle):
  - Only one request: it is granted.
  - Both requesting: d wins unless starve_cnt == MAX_WAIT, in which case if wins.
  - Neither requesting: no grant.
  - Exactly one gnt is asserted at most.
- rom_addr:
  - Driven with the granted port's address, with bits [1:0] forced to 0.
  - With no grant, drives last_addr (the last granted address), so the ROM output stays stable.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) on cycles with if_req && !if_gnt.
  - Clears on if_gnt or !if_req.
  - Guarantees fetch is denied at most MAX_WAIT consecutive cycles.
- Response FSM, rsp_state = {RSP_NONE, RSP_IF, RSP_D}, updated every cycle from this cycle's grant:
  - if_gnt → RSP_IF: next cycle if_rvalid=1, if_rdata = captured rom_data.
  - d_gnt with a legal address → RSP_D: next cycle d_rvalid=1, d_rdata = rom_data, d_err=0.
  - d_gnt with an illegal address → RSP_D: next cycle d_rvalid=1, d_rdata=0, d_err=1.
  - No grant → RSP_NONE: all rvalid=0.
- Outputs and throughput:
  - rvalid signals are single-cycle pulses.
  - rdata holds its last value when rvalid=0.
  - Back-to-back grants on the same or alternating ports give full throughput, 1 response per cycle.
- Illegal data access: d_addr[1:0] != 0, or d_addr[ADDR_W-1:2] >= DEPTH. The request is still granted, and the ROM is not consulted for data.
- Fetch out-of-range: no error flag. The word index wraps modulo DEPTH.
- Reset mid-operation: a response pending from the grant cycle is dropped; no rvalid in the cycle after reset deasserts.
- Requesters must not change addr while req is held and ungranted. The arbiter does not check this.

Decomposition:
- Shared package rom_arb_pkg holds:
  - typedef enum logic [1:0] rsp_state_t {RSP_NONE, RSP_IF, RSP_D};
  - localparams WORD_BYTES=4 and ROM_BYTES=DEPTH*4.
- No sub-module: the arbiter, counter and response FSM fit in one module.
- The ROM stays a separate instance at top level and connects via rom_addr/rom_data.

Test Plan:
- Fetch only: if_req=1, if_addr=0x004 for 3 cycles; ROM word1=0x200005B7 → if_gnt each cycle, if_rvalid from cycle 2, if_rdata=0x200005B7, d_* idle.
- Data only, legal: d_addr=0x010, word4=0x0000F537 → d_gnt same cycle, next cycle d_rvalid=1, d_rdata=0x0000F537, d_err=0.
- Contention with MAX_WAIT=4: both held continuously → grants d,d,d,d,if,d,d,d,d,if…; the fetch grant comes on the 5th contended cycle; starve_cnt never exceeds 4.
- Illegal data: d_addr=0x012 → d_rvalid=1, d_err=1, d_rdata=0. d_addr=0x800 (word 512 ≥ DEPTH) → d_err=1.
- Idle hold: grant at 0x020, then no requests for 3 cycles → rom_addr stays 0x020, all rvalid=0.
- Reset mid-op: assert reset in the same cycle as if_gnt at 0x008 → no if_rvalid afterwards; all outputs 0; first post-reset grant responds normally.
